instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front-end producer that feeds the instruction buffer.
- Generates sequential fetch PCs from RESET_PC and issues one fetch-block request at a time to the ICache.
- Packs each returned block into IF_WIDTH instr_buffer_info_t slots and presents them only while the buffer is not stalling.
- Backend redirects (flush or branch miss) restart fetch at a new PC and discard any in-flight response.

Parameters:
- IF_WIDTH, 2, instructions per fetch block and output slots; power of two.
- RESET_PC, 32'h1c00_0000, first fetch address after reset.
- ADDR_WIDTH, 32, PC width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- stallreq_i  in  1  buffer cannot take a write this cycle.
- redirect_i  in  1  backend flush/redirect.
- redirect_pc_i  in  ADDR_WIDTH  new fetch PC; word aligned.
- icache_req_valid_o  out  1  request valid.
- icache_req_ready_i  in  1  ICache accepts request.
- icache_req_pc_o  out  ADDR_WIDTH  block-aligned request address.
- icache_rsp_valid_i  in  1  response valid, single-cycle pulse.
- icache_rsp_data_i  in  IF_WIDTH*32  block words; word k at [32k+31:32k].
- instr_o  out  instr_buffer_info_t[IF_WIDTH]  slots to the buffer (valid, pc, instr).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; all state updates on posedge clk only.
- Reset values: fetch_pc=RESET_PC; FSM=REQ; hold register empty; icache_req_valid_o=0 in the reset cycle; all instr_o slots zero (valid=0).
- Block alignment: OFFS=$clog2(IF_WIDTH)+2. icache_req_pc_o = {fetch_pc[ADDR_WIDTH-1:OFFS], OFFS'b0}. First useful word s = fetch_pc[OFFS-1:2].
- FSM states:
  - REQ: icache_req_valid_o=1. On req_ready -> WAIT.
  - WAIT: on rsp_valid, load hold register -> HOLD.
  - HOLD: hold valid, waiting to emit. When emitted -> REQ with the next PC.
  - DROP: a stale response is outstanding. On rsp_valid, discard it -> REQ.
- Packing on load: slot j (j < IF_WIDTH-s) gets word s+j, pc = block_base + 4*(s+j), valid=1. Remaining slots valid=0, pc and instr zero. Valid slots are always contiguous from slot 0.
- Emission: instr_o[j].valid = hold_slot_valid[j] & ~stallreq_i & ~redirect_i; pc and instr driven from hold. Emission happens in a cycle where the hold is valid, stallreq_i=0 and redirect_i=0. That cycle: hold cleared, fetch_pc = block_base + 4*IF_WIDTH (wraps modulo 2^ADDR_WIDTH), FSM -> REQ.
- Latency: response cycle -> earliest emission next cycle -> next request the cycle after. Minimum 3 cycles per block when the ICache answers in 1.
- Stall: while stallreq_i=1, hold is kept unchanged; no new request is issued.
- Redirect (highest priority, any state):
  - fetch_pc = redirect_pc_i; hold cleared; no emission that cycle.
  - From WAIT, or from REQ with req_ready=1 in that same cycle: -> DROP.
  - Otherwise: -> REQ.
  - Redirect in DROP: stay in DROP, update fetch_pc.
  - rsp_valid coincident with redirect in WAIT: response discarded; -> REQ, since nothing is left in flight.
- Reset mid-operation: an ICache response arriving after reset is ignored, because the FSM is in REQ.
- Outstanding requests: never more than one. icache_req_valid_o only in REQ, and deasserted in any redirect cycle.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_blocks_o[31:0] (+1 per emission), perf_stall_cycles_o[31:0] (+1 per cycle in HOLD with stallreq_i=1) and perf_drop_o[31:0] (+1 per discarded response). All zero on reset; wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: IFU state enum (REQ/WAIT/HOLD/DROP) and RESET_PC default constant.
- instr_buffer_info_t stays in instr_info.sv.
- One natural sub-module: ifu_block_packer, combinational, (block data, base PC, start offset) -> IF_WIDTH slots. Unit-testable on its own.

Test Plan:
- Reset, ICache ready=1 and 1-cycle response, stallreq=0 -> first request pc 0x1c000000; instr_o pcs 0x1c000000/0x1c000004 both valid; next request 0x1c000008.
- Redirect to 0x1c000104 -> request pc 0x1c000100; slot0 = pc 0x1c000104 with word1; slot1 valid=0; next request 0x1c000108.
- Response arrives while stallreq=1 for 5 cycles -> instr_o valid=0 for 5 cycles, no new request; emitted on the cycle stallreq falls; counter stall=5 if IFU_PERF_CNT_EN.
- Redirect to 0x1c000200 during WAIT, response 2 cycles later -> response discarded (perf_drop=1); next request 0x1c000200 only after the discard.
- Redirect coincident with emission (hold valid, stallreq=0) -> no valid slot that cycle; next request is the redirect PC.
- fetch_pc 0xFFFFFFF8 -> next request 0x00000000 (wrap); rst asserted while in WAIT -> outputs zero, request re-issued at RESET_PC, late response ignored.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
//   Types and constants shared by the instruction fetch unit and its packer.
//
//   ifu_state_e          : fetch FSM state encoding
//   IFU_RESET_PC_DEFAULT : default first fetch address after reset
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IFU_REQ  = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_HOLD = 2'd2,
    IFU_DROP = 2'd3
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC_DEFAULT = 32'h1c00_0000;

endpackage

// File: rtl/instr_info.sv
// -----------------------------------------------------------------------------
// instr_info
//   Shared instruction-buffer slot type. Used by the fetch unit for its output
//   slots and by the instruction buffer that consumes them.
//
//   instr_buffer_info_t
//     valid : slot carries a real instruction
//     pc    : byte address of the instruction
//     instr : raw 32-bit instruction word
// -----------------------------------------------------------------------------
package instr_info;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } instr_buffer_info_t;

endpackage

// File: rtl/ifu_block_packer.sv
// -----------------------------------------------------------------------------
// ifu_block_packer
//   Combinational packing of one ICache fetch block into IF_WIDTH buffer slots.
//   Slot j receives block word (start + j) while that index stays inside the
//   block; later slots are returned all-zero. Valid slots are therefore always
//   contiguous from slot 0.
//
// Ports
//   data_i    : block words, word k at [32k+31:32k]
//   base_pc_i : block-aligned address of word 0
//   start_i   : index of the first useful word in the block
//   slots_o   : packed output slots
// -----------------------------------------------------------------------------
module ifu_block_packer
  import instr_info::*;
#(
  parameter int unsigned IF_WIDTH   = 2,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [IF_WIDTH*32-1:0]             data_i,
  input  logic [ADDR_WIDTH-1:0]              base_pc_i,
  input  logic [$clog2(IF_WIDTH)-1:0]        start_i,
  output instr_buffer_info_t [IF_WIDTH-1:0]  slots_o
);

  localparam int unsigned SW = $clog2(IF_WIDTH);
  localparam int unsigned IW = SW + 1;

  logic [IF_WIDTH-1:0][31:0] words;
  assign words = data_i;

  // start + j is below 2*IF_WIDTH, so the extra top bit of idx is exactly the
  // "ran past the end of the block" flag.
  always_comb begin
    logic [IW-1:0] idx;
    idx     = '0;
    slots_o = '0;
    for (int unsigned j = 0; j < IF_WIDTH; j++) begin
      idx = {1'b0, start_i} + IW'(j);
      if (!idx[SW]) begin
        slots_o[j].valid = 1'b1;
        slots_o[j].pc    = 32'(base_pc_i + ADDR_WIDTH'({idx[SW-1:0], 2'b00}));
        slots_o[j].instr = words[idx[SW-1:0]];
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Front-end producer for the instruction buffer. Walks sequential fetch
//   blocks starting at RESET_PC, keeps at most one ICache request outstanding,
//   packs each returned block into IF_WIDTH slots and presents them while the
//   buffer is not stalling. Backend redirects restart fetch at a new PC and any
//   response still in flight is discarded.
//
//   Optional build macro IFU_PERF_CNT_EN adds three 32-bit wrapping counters:
//   emitted blocks, stalled HOLD cycles and discarded responses.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   stallreq_i          : buffer cannot accept a write this cycle
//   redirect_i          : backend flush / branch-miss redirect
//   redirect_pc_i       : new fetch PC (word aligned)
//   icache_req_valid_o  : request valid
//   icache_req_ready_i  : ICache accepts request
//   icache_req_pc_o     : block-aligned request address
//   icache_rsp_valid_i  : single-cycle response pulse
//   icache_rsp_data_i   : block words, word k at [32k+31:32k]
//   instr_o             : output slots to the instruction buffer
//   perf_*_o            : performance counters (IFU_PERF_CNT_EN only)
//
// State | meaning
// ------+-----------------------------------------------------------
// REQ   | request for current block is presented to the ICache
// WAIT  | request accepted, waiting for the response pulse
// HOLD  | block packed in the hold register, waiting to be emitted
// DROP  | a stale response is still outstanding and will be discarded
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
  import instr_info::*;
#(
  parameter int unsigned            IF_WIDTH   = 2,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(IFU_RESET_PC_DEFAULT)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              stallreq_i,
  input  logic                              redirect_i,
  input  logic [ADDR_WIDTH-1:0]             redirect_pc_i,
  output logic                              icache_req_valid_o,
  input  logic                              icache_req_ready_i,
  output logic [ADDR_WIDTH-1:0]             icache_req_pc_o,
  input  logic                              icache_rsp_valid_i,
  input  logic [IF_WIDTH*32-1:0]            icache_rsp_data_i,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]                       perf_fetch_blocks_o,
  output logic [31:0]                       perf_stall_cycles_o,
  output logic [31:0]                       perf_drop_o,
`endif
  output instr_buffer_info_t [IF_WIDTH-1:0] instr_o
);

  localparam int unsigned OFFS = $clog2(IF_WIDTH) + 2;
  localparam logic [ADDR_WIDTH-1:0] BLOCK_BYTES = ADDR_WIDTH'(4 * IF_WIDTH);

  ifu_state_e                        state, state_nxt;
  logic [ADDR_WIDTH-1:0]             fetch_pc, fetch_pc_nxt;
  instr_buffer_info_t [IF_WIDTH-1:0] hold, hold_nxt;
  instr_buffer_info_t [IF_WIDTH-1:0] packed_slots;
  logic [ADDR_WIDTH-1:0]             block_base;
  logic                              emit;
  logic                              drop;

  // The byte-offset bits of fetch_pc are carried along but never decoded.
  logic unused_pc_bits;
  assign unused_pc_bits = ^fetch_pc[1:0];

  assign block_base = {fetch_pc[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};

  ifu_block_packer #(
    .IF_WIDTH   (IF_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_packer (
    .data_i    (icache_rsp_data_i),
    .base_pc_i (block_base),
    .start_i   (fetch_pc[OFFS-1:2]),
    .slots_o   (packed_slots)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IFU_REQ;
      fetch_pc <= RESET_PC;
      hold     <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      hold     <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    hold_nxt     = hold;
    emit         = 1'b0;
    drop         = 1'b0;

    if (redirect_i) begin
      fetch_pc_nxt = redirect_pc_i;
      hold_nxt     = '0;
      unique case (state)
        // A request handed over in this cycle, or one already accepted, will
        // still produce a response that must be swallowed.
        IFU_REQ: state_nxt = icache_req_ready_i ? IFU_DROP : IFU_REQ;
        IFU_WAIT: begin
          if (icache_rsp_valid_i) begin
            drop      = 1'b1;
            state_nxt = IFU_REQ;
          end else begin
            state_nxt = IFU_DROP;
          end
        end
        // If the stale response lands together with another redirect there is
        // nothing left in flight, so leaving DROP avoids waiting forever.
        IFU_DROP: begin
          if (icache_rsp_valid_i) begin
            drop      = 1'b1;
            state_nxt = IFU_REQ;
          end else begin
            state_nxt = IFU_DROP;
          end
        end
        default: state_nxt = IFU_REQ;
      endcase
    end else begin
      unique case (state)
        IFU_REQ: begin
          if (icache_req_ready_i) state_nxt = IFU_WAIT;
        end
        IFU_WAIT: begin
          if (icache_rsp_valid_i) begin
            hold_nxt  = packed_slots;
            state_nxt = IFU_HOLD;
          end
        end
        IFU_HOLD: begin
          if (!stallreq_i) begin
            emit         = 1'b1;
            hold_nxt     = '0;
            fetch_pc_nxt = block_base + BLOCK_BYTES;
            state_nxt    = IFU_REQ;
          end
        end
        IFU_DROP: begin
          if (icache_rsp_valid_i) begin
            drop      = 1'b1;
            state_nxt = IFU_REQ;
          end
        end
        default: state_nxt = IFU_REQ;
      endcase
    end
  end

  assign icache_req_valid_o = (state == IFU_REQ) && !redirect_i && !rst;
  assign icache_req_pc_o    = block_base;

  // hold is zero outside HOLD, so gating valid here is enough for emission.
  always_comb begin
    instr_o = hold;
    for (int unsigned j = 0; j < IF_WIDTH; j++) begin
      instr_o[j].valid = hold[j].valid & ~stallreq_i & ~redirect_i & ~rst;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_blocks_q, perf_stall_q, perf_drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_blocks_q <= '0;
      perf_stall_q  <= '0;
      perf_drop_q   <= '0;
    end else begin
      if (emit)                                perf_blocks_q <= perf_blocks_q + 32'd1;
      if ((state == IFU_HOLD) && stallreq_i)   perf_stall_q  <= perf_stall_q + 32'd1;
      if (drop)                                perf_drop_q   <= perf_drop_q + 32'd1;
    end
  end

  assign perf_fetch_blocks_o = perf_blocks_q;
  assign perf_stall_cycles_o = perf_stall_q;
  assign perf_drop_o         = perf_drop_q;
`else
  logic unused_perf;
  assign unused_perf = emit ^ drop;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import instr_info::*;

  logic        clk;
  logic        rst;
  logic        stallreq_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        icache_req_valid_o;
  logic        icache_req_ready_i;
  logic [31:0] icache_req_pc_o;
  logic        icache_rsp_valid_i;
  logic [63:0] icache_rsp_data_i;
  instr_buffer_info_t [1:0] instr_o;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_blocks_o;
  logic [31:0] perf_stall_cycles_o;
  logic [31:0] perf_drop_o;
`endif

  int checks   = 0;
  int failures = 0;

  instr_fetch_unit dut (
    .clk                (clk),
    .rst                (rst),
    .stallreq_i         (stallreq_i),
    .redirect_i         (redirect_i),
    .redirect_pc_i      (redirect_pc_i),
    .icache_req_valid_o (icache_req_valid_o),
    .icache_req_ready_i (icache_req_ready_i),
    .icache_req_pc_o    (icache_req_pc_o),
    .icache_rsp_valid_i (icache_rsp_valid_i),
    .icache_rsp_data_i  (icache_rsp_data_i),
`ifdef IFU_PERF_CNT_EN
    .perf_fetch_blocks_o(perf_fetch_blocks_o),
    .perf_stall_cycles_o(perf_stall_cycles_o),
    .perf_drop_o        (perf_drop_o),
`endif
    .instr_o            (instr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_buffer_info_t slot(input logic v, input logic [31:0] pc,
                                              input logic [31:0] ins);
    instr_buffer_info_t s;
    s.valid = v;
    s.pc    = pc;
    s.instr = ins;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs mid-period; outputs are checked 1 ns later,
  // well away from the next rising edge.
  task automatic drive(input logic r, input logic st, input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic rv, input logic [63:0] d);
    @(negedge clk);
    rst                = r;
    stallreq_i         = st;
    redirect_i         = rd;
    redirect_pc_i      = rpc;
    icache_req_ready_i = rdy;
    icache_rsp_valid_i = rv;
    icache_rsp_data_i  = d;
    #1;
  endtask

  function automatic logic [1:0] vbits();
    return {instr_o[1].valid, instr_o[0].valid};
  endfunction

  initial begin
    rst = 1'b1; stallreq_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    icache_req_ready_i = 1'b0; icache_rsp_valid_i = 1'b0; icache_rsp_data_i = '0;

    // reset
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 0);
    chk("rst_req_valid", icache_req_valid_o, 1'b0);
    chk("rst_instr", instr_o, '0);

    // first block, sequential fetch
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("a1_req_valid", icache_req_valid_o, 1'b1);
    chk("a1_req_pc", icache_req_pc_o, 32'h1c00_0000);
`ifdef IFU_PERF_CNT_EN
    chk("perf_blocks_rst", perf_fetch_blocks_o, 32'd0);
`endif
    drive(0, 0, 0, 0, 0, 1, {32'h1111_0001, 32'h1111_0000});
    chk("a2_req_valid", icache_req_valid_o, 1'b0);
    chk("a2_vbits", vbits(), 2'b00);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("a3_slot0", instr_o[0], slot(1, 32'h1c00_0000, 32'h1111_0000));
    chk("a3_slot1", instr_o[1], slot(1, 32'h1c00_0004, 32'h1111_0001));
    chk("a3_req_valid", icache_req_valid_o, 1'b0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("a4_req_pc", icache_req_pc_o, 32'h1c00_0008);
    chk("a4_req_valid", icache_req_valid_o, 1'b1);

    // redirect during WAIT to an odd word of a block
    drive(0, 0, 1, 32'h1c00_0104, 0, 0, 0);
    chk("a5_req_valid_redir", icache_req_valid_o, 1'b0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("a6_drop_no_req", icache_req_valid_o, 1'b0);
    drive(0, 0, 0, 0, 1, 1, 64'hdead_beef_dead_beef);
    chk("a6b_drop_no_req", icache_req_valid_o, 1'b0);
    chk("a6b_vbits", vbits(), 2'b00);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("a7_req_valid", icache_req_valid_o, 1'b1);
    chk("a7_req_pc", icache_req_pc_o, 32'h1c00_0100);
    drive(0, 0, 0, 0, 0, 1, {32'h2222_0001, 32'h2222_0000});
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("a9_slot0", instr_o[0], slot(1, 32'h1c00_0104, 32'h2222_0001));
    chk("a9_slot1", instr_o[1], slot(0, 32'h0, 32'h0));
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("a10_req_pc", icache_req_pc_o, 32'h1c00_0108);
    chk("a10_req_valid", icache_req_valid_o, 1'b1);

    // response lands while the buffer stalls; 5 stalled HOLD cycles
    drive(0, 1, 0, 0, 0, 1, {32'h3333_0001, 32'h3333_0000});
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 1, 0, 0);
      chk("stall_vbits", vbits(), 2'b00);
      chk("stall_no_req", icache_req_valid_o, 1'b0);
      chk("stall_hold_pc", instr_o[0].pc, 32'h1c00_0108);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("a17_slot0", instr_o[0], slot(1, 32'h1c00_0108, 32'h3333_0000));
    chk("a17_slot1", instr_o[1], slot(1, 32'h1c00_010c, 32'h3333_0001));

    // redirect during WAIT, response 2 cycles later
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("a18_req_pc", icache_req_pc_o, 32'h1c00_0110);
`ifdef IFU_PERF_CNT_EN
    chk("perf_stall_5", perf_stall_cycles_o, 32'd5);
    chk("perf_blocks_3", perf_fetch_blocks_o, 32'd3);
`endif
    drive(0, 0, 1, 32'h1c00_0200, 0, 0, 0);
    chk("a19_req_valid_redir", icache_req_valid_o, 1'b0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("a20_drop_no_req", icache_req_valid_o, 1'b0);
    drive(0, 0, 0, 0, 1, 1, {32'h9999_0001, 32'h9999_0000});
    chk("a21_drop_no_req", icache_req_valid_o, 1'b0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("a22_req_valid", icache_req_valid_o, 1'b1);
    chk("a22_req_pc", icache_req_pc_o, 32'h1c00_0200);
`ifdef IFU_PERF_CNT_EN
    chk("perf_drop_2", perf_drop_o, 32'd2);
`endif
    drive(0, 0, 0, 0, 0, 1, {32'h4444_0001, 32'h4444_0000});

    // redirect coincident with would-be emission
    drive(0, 0, 1, 32'h1c00_0300, 0, 0, 0);
    chk("a24_vbits_redir", vbits(), 2'b00);
    chk("a24_req_valid", icache_req_valid_o, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("a25_req_valid", icache_req_valid_o, 1'b1);
    chk("a25_req_pc", icache_req_pc_o, 32'h1c00_0300);
    chk("a25_vbits", vbits(), 2'b00);
`ifdef IFU_PERF_CNT_EN
    chk("perf_blocks_still_3", perf_fetch_blocks_o, 32'd3);
`endif

    // address wrap
    drive(0, 0, 1, 32'hffff_fff8, 0, 0, 0);
    chk("a26_req_valid_redir", icache_req_valid_o, 1'b0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("a27_req_pc", icache_req_pc_o, 32'hffff_fff8);
    chk("a27_req_valid", icache_req_valid_o, 1'b1);
    drive(0, 0, 0, 0, 0, 1, {32'h5555_0001, 32'h5555_0000});
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("a29_slot0", instr_o[0], slot(1, 32'hffff_fff8, 32'h5555_0000));
    chk("a29_slot1", instr_o[1], slot(1, 32'hffff_fffc, 32'h5555_0001));
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("a30_req_pc_wrap", icache_req_pc_o, 32'h0000_0000);
    chk("a30_req_valid", icache_req_valid_o, 1'b1);

    // reset while in WAIT, late response afterwards
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("a31_rst_req_valid", icache_req_valid_o, 1'b0);
    chk("a31_rst_instr", instr_o, '0);
    drive(0, 0, 0, 0, 0, 1, {32'h7777_0001, 32'h7777_0000});
    chk("a32_req_valid", icache_req_valid_o, 1'b1);
    chk("a32_req_pc", icache_req_pc_o, 32'h1c00_0000);
`ifdef IFU_PERF_CNT_EN
    chk("perf_blocks_rst2", perf_fetch_blocks_o, 32'd0);
    chk("perf_stall_rst2", perf_stall_cycles_o, 32'd0);
    chk("perf_drop_rst2", perf_drop_o, 32'd0);
`endif
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("a33_vbits", vbits(), 2'b00);
    chk("a33_req_valid", icache_req_valid_o, 1'b1);
    chk("a33_req_pc", icache_req_pc_o, 32'h1c00_0000);
    drive(0, 0, 0, 0, 0, 1, {32'h6666_0001, 32'h6666_0000});
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("a35_slot0", instr_o[0], slot(1, 32'h1c00_0000, 32'h6666_0000));
    chk("a35_slot1", instr_o[1], slot(1, 32'h1c00_0004, 32'h6666_0001));
`ifdef IFU_PERF_CNT_EN
    chk("perf_drop_late_ignored", perf_drop_o, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
